// File: rtl/div32_pkg.sv
// Shared definitions for the sequential divider: state encoding, default width
// and the signed-overflow operand pair (most-negative / -1).
package div32_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [DIV_WIDTH-1:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left, trial-subtract the divisor
// with a carry-in-1 add of its complement, keep the difference or restore.
module div_step
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             carry;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = {1'b0, shifted} + {1'b0, ~{1'b0, divisor_i}} + {{(WIDTH+1){1'b0}}, 1'b1};

    // shifted < 2*divisor, so a successful subtract always leaves bit WIDTH clear
    assign carry = trial[WIDTH+1] & ~trial[WIDTH];

    assign rem_o = carry ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], carry};

endmodule

// File: rtl/div32_seq.sv
// Sequential restoring divider, one quotient bit per cycle.
// Define DIV32_SIGNED_EN to honour is_signed (magnitude conversion, FIX state, overflow).
module div32_seq
    import div32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] remWork_q, remWork_d;
    logic [WIDTH-1:0] quoWork_q, quoWork_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             negQuo_q, negQuo_d;
    logic             negRem_q, negRem_d;
    logic             signedOp_q, signedOp_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic             signedReq;
    logic             dividendNeg;
    logic             divisorNeg;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;
    logic             isOverflow;
    logic [WIDTH-1:0] stepRem;
    logic [WIDTH-1:0] stepQuo;

`ifdef DIV32_SIGNED_EN
    assign signedReq = is_signed;
`else
    assign signedReq = is_signed & 1'b0;
`endif

    assign dividendNeg = signedReq & dividend[WIDTH-1];
    assign divisorNeg  = signedReq & divisor[WIDTH-1];
    assign dividendMag = dividendNeg ? -dividend : dividend;
    assign divisorMag  = divisorNeg ? -divisor : divisor;
    assign isOverflow  = signedReq && (dividend == WIDTH'(OVF_DIVIDEND))
                                   && (divisor == WIDTH'(OVF_DIVISOR));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (remWork_q),
        .quo_i     (quoWork_q),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .quo_o     (stepQuo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            remWork_q   <= '0;
            quoWork_q   <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            negQuo_q    <= 1'b0;
            negRem_q    <= 1'b0;
            signedOp_q  <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            remWork_q   <= remWork_d;
            quoWork_q   <= quoWork_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            negQuo_q    <= negQuo_d;
            negRem_q    <= negRem_d;
            signedOp_q  <= signedOp_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Results only move on entry to DONE, so they stay stable until the next accepted start.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        remWork_d   = remWork_q;
        quoWork_d   = quoWork_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        negQuo_d    = negQuo_q;
        negRem_d    = negRem_q;
        signedOp_d  = signedOp_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    dbz_d      = 1'b0;
                    ovf_d      = 1'b0;
                    negQuo_d   = dividendNeg ^ divisorNeg;
                    negRem_d   = dividendNeg;
                    signedOp_d = signedReq;
                    divisor_d  = divisorMag;
                    quoWork_d  = dividendMag;
                    remWork_d  = '0;
                    cnt_d      = LAST_COUNT;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        dbz_d       = 1'b1;
                        quotient_d  = '1;
                        remainder_d = dividend;
                    end else if (isOverflow) begin
                        state_d     = DONE;
                        ovf_d       = 1'b1;
                        quotient_d  = WIDTH'(OVF_DIVIDEND);
                        remainder_d = '0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                remWork_d = stepRem;
                quoWork_d = stepQuo;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    if (signedOp_q) begin
                        state_d = FIX;
                    end else begin
                        state_d     = DONE;
                        quotient_d  = stepQuo;
                        remainder_d = stepRem;
                    end
                end
            end
            FIX: begin
                quotient_d  = negQuo_q ? -quoWork_q : quoWork_q;
                remainder_d = negRem_q ? -remWork_q : remWork_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == CALC) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

`ifdef DIV32_SIGNED_EN
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_div32_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    div32_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected results straight from the arithmetic definition of the operation.
    task automatic refModel(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] q, output logic [31:0] r,
                            output bit dbz, output bit ovf, output int lat);
        bit useSigned;
        int sa;
        int sb;
`ifdef DIV32_SIGNED_EN
        useSigned = sgn;
`else
        useSigned = 1'b0;
`endif
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dbz = 1'b1; lat = 1;
        end else if (useSigned && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0; ovf = 1'b1; lat = 1;
        end else if (useSigned) begin
            sa = a; sb = b;
            q = sa / sb; r = sa % sb; lat = 34;
        end else begin
            q = a / b; r = a % b; lat = 33;
        end
    endtask

    task automatic applyStimulus(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'(($urandom));
    endtask

    task automatic runDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int injectAt);
        logic [31:0] q;
        logic [31:0] r;
        bit dbz;
        bit ovf;
        int lat;
        int cyc;
        int busyCnt;
        refModel(sgn, a, b, q, r, dbz, ovf, lat);
        applyStimulus(sgn, a, b);
        cyc = 1;
        busyCnt = 0;
        while (!done && cyc < 80) begin
            if (busy) busyCnt++;
            if (cyc == injectAt) begin
                start    = 1'b1;
                dividend = 32'd5;
                divisor  = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        checkOutput("latency", cyc, lat);
        checkOutput("busyCycles", busyCnt, lat - 1);
        checkOutput("busyAtDone", busy, 1'b0);
        checkOutput("quotient", quotient, q);
        checkOutput("remainder", remainder, r);
        checkOutput("divByZero", div_by_zero, dbz);
        checkOutput("overflow", overflow, ovf);
        @(posedge clk);
        #1;
        checkOutput("donePulse", done, 1'b0);
        checkOutput("holdQuotient", quotient, q);
        checkOutput("holdRemainder", remainder, r);
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "Busy"}, busy, 1'b0);
        checkOutput({tag, "Done"}, done, 1'b0);
        checkOutput({tag, "Quotient"}, quotient, 32'd0);
        checkOutput({tag, "Remainder"}, remainder, 32'd0);
        checkOutput({tag, "DivByZero"}, div_by_zero, 1'b0);
        checkOutput({tag, "Overflow"}, overflow, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkIdleZero("reset");
        @(negedge clk);
        rst = 1'b0;

        runDiv(1'b0, 32'd100, 32'd7, 0);
        runDiv(1'b0, 32'd5, 32'd0, 0);
        runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        runDiv(1'b1, 32'd9, 32'hFFFF_FFFD, 0);
        runDiv(1'b1, 32'd0, 32'd0, 0);

        // A start pulsed mid-division must be ignored.
        runDiv(1'b0, 32'd100, 32'd7, 10);

        // Reset at cycle 15 of a division, with a competing start that would
        // otherwise complete immediately (divisor 0).
        applyStimulus(1'b0, 32'd123456, 32'd3);
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd0;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        checkIdleZero("midReset");
        @(posedge clk);
        #1;
        checkOutput("afterResetBusy", busy, 1'b0);
        checkOutput("afterResetDone", done, 1'b0);

        runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 0);

        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom_range(0, 15);
                1:       b = $urandom;
                2:       b = a >> $urandom_range(1, 31);
                default: b = 32'hFFFF_FFFF - $urandom_range(0, 3);
            endcase
            runDiv(1'($urandom_range(0, 1)), a, b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/div32_seq.md
DIV32_SEQ -- requirements
Module: div32_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is verified.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a division.
REQ-005 SHALL have port is_signed, input, 1, high selects two's-complement operands.
REQ-006 SHALL have port dividend, input, WIDTH, numerator; sampled only on an accepted start.
REQ-007 SHALL have port divisor, input, WIDTH, denominator; sampled only on an accepted start.
REQ-008 SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when results are valid.
REQ-010 SHALL have port quotient, output, WIDTH, registered result.
REQ-011 SHALL have port remainder, output, WIDTH, registered result.
REQ-012 SHALL have port div_by_zero, output, 1, set when the last accepted divisor was 0.
REQ-013 SHALL have port overflow, output, 1, set for signed most-negative / -1.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-015 SHALL accept start only in IDLE or DONE, and SHALL ignore start while busy.
REQ-016 SHALL, on acceptance, latch the operands, clear the flags, and enter CALC with the iteration counter set to WIDTH-1.
REQ-017 SHALL, in CALC, perform one restoring step per cycle: shift {rem,quo} left 1, trial-subtract the divisor from the remainder via a WIDTH+1-bit add of the inverted divisor with carry-in 1, keep the difference and set the quotient LSB when carry-out is 1, else restore and clear the LSB.
REQ-018 SHALL leave CALC after exactly WIDTH steps, going to FIX if signed correction is enabled and active, else to DONE.
REQ-019 SHALL, in FIX, negate the quotient when the operand signs differ and negate the remainder when the dividend is negative, in one cycle.
REQ-020 SHALL assert done only in the DONE state, for one cycle, then return to IDLE; done latency = WIDTH+1 cycles after start is accepted (unsigned) or WIDTH+2 (signed).
REQ-021 SHALL assert busy in CALC and FIX only.
REQ-022 SHALL, for divisor 0, skip CALC, go directly to DONE (done 1 cycle after start), and output quotient all-ones, remainder = dividend, div_by_zero=1.
REQ-023 SHALL, for signed 0x80000000 / 0xFFFFFFFF, skip CALC, go directly to DONE, and output quotient 0x80000000, remainder 0, overflow=1.
REQ-024 SHALL hold quotient, remainder and the flags stable from done until the next accepted start.
REQ-025 SHALL give div_by_zero priority over overflow.

Reset
REQ-026 SHALL, on rst high at a clock edge (including mid-CALC/FIX), enter IDLE and clear busy, done, quotient, remainder, div_by_zero and overflow to 0.
REQ-027 SHALL give rst priority over a simultaneous start.

Configuration
REQ-028 SHALL use macro DIV32_SIGNED_EN: when defined, is_signed is honoured, operands are converted to magnitude on acceptance, and FIX/overflow are active.
REQ-029 SHALL, when DIV32_SIGNED_EN is undefined, ignore is_signed, treat all operands as unsigned, never enter FIX, tie overflow to 0, and have done latency always WIDTH+1.

Structure
REQ-030 SHALL place the FSM state enum, WIDTH default and the overflow operand constants in shared package div32_pkg.
REQ-031 SHALL implement the single restoring step (shift, trial subtract, select) as sub-module div_step, instantiated once.

Verification
REQ-032 SHALL cover: unsigned 100/7 -> quotient 14, remainder 2, done exactly 33 cycles after start, busy high cycles 1-32.
REQ-033 SHALL cover: 5/0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1, done 1 cycle after start.
REQ-034 SHALL cover: signed -7/2 (macro on) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, done at cycle 34; with the macro off -> unsigned result 0x7FFFFFFC, remainder 1, done at cycle 33.
REQ-035 SHALL cover: signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1.
REQ-036 SHALL cover: start pulsed at cycle 10 of a busy division -> ignored, first result unchanged; rst at cycle 15 -> all outputs 0, IDLE, next start 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
